// File: rtl/clint_reg_arbiter.sv
// Round-robin arbiter sharing the CLINT register port between NR_REQ requesters.
// One access in flight at a time. Illegal offsets are rejected locally, and a timeout aborts hung accesses.
module clint_reg_arbiter #(
    parameter int                    NR_REQ         = 2,
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    TIMEOUT_CYCLES = 64,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT     = 16'hC000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NR_REQ-1:0]            req_valid_i,
    output logic [NR_REQ-1:0]            req_ready_o,
    input  logic [NR_REQ-1:0]            req_we_i,
    input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NR_REQ*64-1:0]         req_wdata_i,
    input  logic [NR_REQ*8-1:0]          req_be_i,
    output logic [NR_REQ-1:0]            rsp_valid_o,
    output logic [63:0]                  rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic                         clint_req_o,
    input  logic                         clint_gnt_i,
    output logic                         clint_we_o,
    output logic [ADDR_WIDTH-1:0]        clint_addr_o,
    output logic [63:0]                  clint_wdata_o,
    output logic [7:0]                   clint_be_o,
    input  logic                         clint_rvalid_i,
    input  logic [63:0]                  clint_rdata_i,
    input  logic                         clint_err_i
);

    localparam int IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_found;
    logic [SUM_W-1:0]        scan;
    logic [SUM_W-1:0]        ptr_inc;
    logic [IDX_W-1:0]        next_ptr;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic                    addr_ok;
    logic                    accept;
    logic                    rsp_done;
    logic                    tmo_hit;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [63:0]             lat_wdata;
    logic [7:0]              lat_be;
    logic [63:0]             rsp_rdata;
    logic                    rsp_err;

    // Scan from rr_ptr upward, wrapping, so the last winner drops to lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            scan = SUM_W'(rr_ptr) + SUM_W'(i);
            if (scan >= SUM_W'(NR_REQ)) begin
                scan = scan - SUM_W'(NR_REQ);
            end
            if (!sel_found && req_valid_i[scan[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan[IDX_W-1:0];
            end
        end
    end

    assign win_addr = req_addr_i[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_ok  = (win_addr < ADDR_LIMIT) && (win_addr[2:0] == 3'b000);
    assign accept   = (state == IDLE) && sel_found && !rst_i;
    assign rsp_done = ((state == ISSUE) && clint_gnt_i && clint_rvalid_i) ||
                      ((state == WAIT_RSP) && clint_rvalid_i);
    assign tmo_hit  = ((state == ISSUE) || (state == WAIT_RSP)) && (tmo_cnt == TMO_LAST);
    assign ptr_inc  = SUM_W'(winner) + SUM_W'(1);
    assign next_ptr = (ptr_inc >= SUM_W'(NR_REQ)) ? '0 : ptr_inc[IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = addr_ok ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (rsp_done || tmo_hit) begin
                    state_next = RESP;
                end else if (clint_gnt_i) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_done || tmo_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Completion wins over a timeout that lands in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr    <= '0;
            winner    <= '0;
            tmo_cnt   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        winner    <= sel_idx;
                        lat_we    <= req_we_i[sel_idx];
                        lat_addr  <= win_addr;
                        lat_wdata <= req_wdata_i[int'(sel_idx)*64 +: 64];
                        lat_be    <= req_be_i[int'(sel_idx)*8 +: 8];
                        tmo_cnt   <= '0;
                        if (!addr_ok) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                ISSUE, WAIT_RSP: begin
                    if (rsp_done) begin
                        rsp_rdata <= lat_we ? 64'd0 : clint_rdata_i;
                        rsp_err   <= clint_err_i;
                    end else if (tmo_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RESP:    rr_ptr <= next_ptr;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        clint_req_o = 1'b0;
        case (state)
            IDLE:     if (accept) req_ready_o[sel_idx] = 1'b1;
            ISSUE:    clint_req_o = 1'b1;
            RESP:     rsp_valid_o[winner] = 1'b1;
            default:  ;
        endcase
    end

    assign clint_we_o    = lat_we;
    assign clint_addr_o  = lat_addr;
    assign clint_wdata_o = lat_wdata;
    assign clint_be_o    = lat_be;
    assign rsp_rdata_o   = rsp_rdata;
    assign rsp_err_o     = rsp_err;

endmodule

// File: tb/tb_clint_reg_arbiter.sv
// Directed bench for clint_reg_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_clint_reg_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 16;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*64-1:0] req_wdata;
    logic [NR*8-1:0] req_be;
    logic [NR-1:0]   rsp_valid;
    logic [63:0]     rsp_rdata;
    logic            rsp_err;
    logic            clint_req;
    logic            clint_gnt;
    logic            clint_we;
    logic [AW-1:0]   clint_addr;
    logic [63:0]     clint_wdata;
    logic [7:0]      clint_be;
    logic            clint_rvalid;
    logic [63:0]     clint_rdata;
    logic            clint_err;

    int vec_count   = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clint_reg_arbiter #(
        .NR_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .ADDR_LIMIT(16'hC000)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .clint_req_o(clint_req), .clint_gnt_i(clint_gnt), .clint_we_o(clint_we),
        .clint_addr_o(clint_addr), .clint_wdata_o(clint_wdata), .clint_be_o(clint_be),
        .clint_rvalid_i(clint_rvalid), .clint_rdata_i(clint_rdata), .clint_err_i(clint_err)
    );

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic we,
                                 input logic [15:0] addr, input logic [63:0] wdata,
                                 input logic [7:0] be);
        req_valid[idx]         = valid;
        req_we[idx]            = we;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*64 +: 64] = wdata;
        req_be[idx*8 +: 8]     = be;
    endtask

    task automatic doReset();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    // Legal access: gnt in the first ISSUE cycle, rvalid the cycle after; ends in the following IDLE cycle.
    task automatic runAccess(input int idx, input logic we, input logic [15:0] addr,
                             input logic [63:0] wdata, input logic [7:0] be,
                             input logic [63:0] rdata, input logic keep);
        logic [NR-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        applyStimulus(idx, 1'b1, we, addr, wdata, be);
        #1;
        checkOutput("ready_c0", 64'(req_ready), 64'(onehot));
        checkOutput("clint_req_c0", 64'(clint_req), 64'd0);
        nextCycle();
        if (!keep) req_valid[idx] = 1'b0;
        clint_gnt = 1'b1;
        #1;
        checkOutput("clint_req_c1", 64'(clint_req), 64'd1);
        checkOutput("clint_addr", 64'(clint_addr), 64'(addr));
        checkOutput("clint_we", 64'(clint_we), 64'(we));
        checkOutput("clint_wdata", clint_wdata, wdata);
        checkOutput("clint_be", 64'(clint_be), 64'(be));
        checkOutput("ready_c1", 64'(req_ready), 64'd0);
        nextCycle();
        clint_gnt    = 1'b0;
        clint_rvalid = 1'b1;
        clint_rdata  = rdata;
        clint_err    = 1'b0;
        #1;
        checkOutput("rsp_early", 64'(rsp_valid), 64'd0);
        nextCycle();
        clint_rvalid = 1'b0;
        #1;
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(onehot));
        checkOutput("rsp_rdata", rsp_rdata, we ? 64'd0 : rdata);
        checkOutput("rsp_err", 64'(rsp_err), 64'd0);
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        clint_gnt = 1'b0; clint_rvalid = 1'b0; clint_rdata = '0; clint_err = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_clint_req", 64'(clint_req), 64'd0);
        checkOutput("rst_clint_addr", 64'(clint_addr), 64'd0);
        checkOutput("rst_rdata", rsp_rdata, 64'd0);
        checkOutput("rst_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;

        $display("[TB] read of last legal word 0xBFF8");
        runAccess(0, 1'b0, 16'hBFF8, 64'd0, 8'hFF, 64'h1234, 1'b0);
        checkOutput("hold_valid", 64'(rsp_valid), 64'd0);
        checkOutput("hold_rdata", rsp_rdata, 64'h1234);

        $display("[TB] alternating writes from both requesters");
        doReset();
        applyStimulus(0, 1'b1, 1'b1, 16'h4000, 64'hA000, 8'h0F);
        applyStimulus(1, 1'b1, 1'b1, 16'h4008, 64'hB000, 8'hF0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                runAccess(0, 1'b1, 16'h4000, 64'hA000 + 64'(k), 8'h0F, 64'hDEAD, 1'b1);
            else
                runAccess(1, 1'b1, 16'h4008, 64'hB000 + 64'(k), 8'hF0, 64'hDEAD, 1'b1);
        end
        req_valid = '0;

        $display("[TB] gnt and rvalid together with clint error");
        applyStimulus(0, 1'b1, 1'b0, 16'h0008, 64'd0, 8'hFF);
        #1;
        checkOutput("same_ready", 64'(req_ready), 64'h1);
        nextCycle();
        req_valid[0] = 1'b0;
        clint_gnt = 1'b1; clint_rvalid = 1'b1; clint_err = 1'b1; clint_rdata = 64'hCAFE;
        #1;
        checkOutput("same_clint_req", 64'(clint_req), 64'd1);
        nextCycle();
        clint_gnt = 1'b0; clint_rvalid = 1'b0; clint_err = 1'b0;
        #1;
        checkOutput("same_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("same_rsp_err", 64'(rsp_err), 64'd1);
        checkOutput("same_rsp_rdata", rsp_rdata, 64'hCAFE);
        nextCycle();

        $display("[TB] illegal addresses from requester 1");
        applyStimulus(1, 1'b1, 1'b0, 16'hC000, 64'd0, 8'hFF);
        #1;
        checkOutput("ill0_ready", 64'(req_ready), 64'h2);
        nextCycle();
        req_valid[1] = 1'b0;
        #1;
        checkOutput("ill0_clint_req", 64'(clint_req), 64'd0);
        checkOutput("ill0_rsp_valid", 64'(rsp_valid), 64'h2);
        checkOutput("ill0_err", 64'(rsp_err), 64'd1);
        checkOutput("ill0_rdata", rsp_rdata, 64'd0);
        nextCycle();
        applyStimulus(1, 1'b1, 1'b0, 16'h0004, 64'd0, 8'hFF);
        #1;
        checkOutput("ill1_ready", 64'(req_ready), 64'h2);
        nextCycle();
        req_valid[1] = 1'b0;
        #1;
        checkOutput("ill1_clint_req", 64'(clint_req), 64'd0);
        checkOutput("ill1_rsp_valid", 64'(rsp_valid), 64'h2);
        checkOutput("ill1_err", 64'(rsp_err), 64'd1);
        checkOutput("ill1_rdata", rsp_rdata, 64'd0);
        nextCycle();

        $display("[TB] timeout with gnt held low");
        runAccess(1, 1'b0, 16'h0010, 64'd0, 8'hFF, 64'h7777, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'h4000, 64'd0, 8'hFF);
        #1;
        checkOutput("tmo_ready", 64'(req_ready), 64'h1);
        for (int k = 1; k <= TMO; k++) begin
            nextCycle();
            req_valid[0] = 1'b0;
            if (k == 1 || k == TMO) begin
                checkOutput("tmo_clint_req", 64'(clint_req), 64'd1);
                checkOutput("tmo_clint_addr", 64'(clint_addr), 64'h4000);
                checkOutput("tmo_rsp_quiet", 64'(rsp_valid), 64'd0);
            end
        end
        nextCycle();
        checkOutput("tmo_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("tmo_err", 64'(rsp_err), 64'd1);
        checkOutput("tmo_rdata", rsp_rdata, 64'd0);
        checkOutput("tmo_clint_req_off", 64'(clint_req), 64'd0);
        nextCycle();
        nextCycle();
        clint_rvalid = 1'b1; clint_rdata = 64'hBAD; clint_err = 1'b0;
        #1;
        checkOutput("late_rsp0", 64'(rsp_valid), 64'd0);
        nextCycle();
        clint_rvalid = 1'b0;
        #1;
        checkOutput("late_rsp1", 64'(rsp_valid), 64'd0);
        checkOutput("late_rdata", rsp_rdata, 64'd0);
        checkOutput("late_err", 64'(rsp_err), 64'd1);
        runAccess(1, 1'b0, 16'h0018, 64'd0, 8'hFF, 64'h5555, 1'b0);

        $display("[TB] reset during WAIT_RSP");
        runAccess(0, 1'b0, 16'h0020, 64'd0, 8'hFF, 64'h9999, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0028, 64'd0, 8'hFF);
        #1;
        checkOutput("rstw_ready", 64'(req_ready), 64'h2);
        nextCycle();
        req_valid[1] = 1'b0;
        clint_gnt = 1'b1;
        nextCycle();
        clint_gnt = 1'b0;
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkOutput("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rstw_clint_req", 64'(clint_req), 64'd0);
        checkOutput("rstw_clint_addr", 64'(clint_addr), 64'd0);
        checkOutput("rstw_rdata", rsp_rdata, 64'd0);
        checkOutput("rstw_err", 64'(rsp_err), 64'd0);
        req_valid = 2'b11;
        #1;
        checkOutput("rstw_rr_ptr", 64'(req_ready), 64'h1);
        req_valid = '0;
        #1;
        runAccess(1, 1'b0, 16'h0030, 64'd0, 8'hFF, 64'h4242, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
